// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port RAM between instruction fetch and data access,
// and steers each next-cycle RAM response back to the requester that owns it.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int INST_WIDTH = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  input  logic                  if_kill_i,
  output logic                  if_gnt_o,
  output logic                  if_stall_o,
  output logic                  if_rvalid_o,
  output logic [INST_WIDTH-1:0] if_rdata_o,
  output logic                  if_err_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  input  logic [2:0]            d_wid_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  d_err_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  output logic [2:0]            ram_wid_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  input  logic                  ram_illegal_i,
  input  logic                  ram_unalign_i
);

  localparam int CNT_W = ($clog2(STARVE_MAX + 1) > 2) ? $clog2(STARVE_MAX + 1) : 2;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  // Fetches are always an unsigned 32-bit word access on the RAM width bus.
  localparam logic [2:0] WID_FETCH = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    RESP_IF,
    RESP_D_LD,
    RESP_D_ST
  } resp_state_t;

  resp_state_t      state_reg;
  resp_state_t      state_next;
  resp_state_t      resp_state;
  logic [CNT_W-1:0] starve_cnt_reg;
  logic [CNT_W-1:0] starve_cnt_next;
  logic             if_win;
  logic             if_gnt;
  logic             d_gnt;

  // Data has priority unless fetch has been starved STARVE_MAX cycles in a row.
  always_comb begin
    if_win = if_req_i & (~d_req_i | (starve_cnt_reg == STARVE_LIM));
    if_gnt = rst_i & if_win;
    d_gnt  = rst_i & d_req_i & ~if_win;
  end

  assign if_gnt_o   = if_gnt;
  assign d_gnt_o    = d_gnt;
  assign if_stall_o = rst_i & if_req_i & ~if_gnt;

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_wid_o   = '0;
    if (if_gnt) begin
      ram_en_o   = 1'b1;
      ram_addr_o = if_addr_i;
      ram_wid_o  = WID_FETCH;
    end else if (d_gnt) begin
      ram_en_o    = 1'b1;
      ram_we_o    = d_we_i;
      ram_addr_o  = d_addr_i;
      ram_wdata_o = d_wdata_i;
      ram_wid_o   = d_wid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // While reset is held the response side behaves as IDLE, so an in-flight
  // access never returns.
  assign resp_state = rst_i ? state_reg : IDLE;

  always_comb begin
    state_next      = IDLE;
    starve_cnt_next = starve_cnt_reg;
    if_rvalid_o     = 1'b0;
    if_rdata_o      = '0;
    if_err_o        = 1'b0;
    d_rvalid_o      = 1'b0;
    d_rdata_o       = '0;
    d_err_o         = 1'b0;

    if (if_gnt) begin
      state_next = RESP_IF;
    end else if (d_gnt) begin
      state_next = d_we_i ? RESP_D_ST : RESP_D_LD;
    end

    if (if_gnt || !if_req_i) begin
      starve_cnt_next = '0;
    end else if (starve_cnt_reg != STARVE_LIM) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end

    case (resp_state)
      RESP_IF: begin
        if_rvalid_o = ~if_kill_i;
        if_rdata_o  = if_kill_i ? '0 : ram_rdata_i[INST_WIDTH-1:0];
        if_err_o    = ram_illegal_i & ~if_kill_i;
      end
      RESP_D_LD: begin
        d_rvalid_o = 1'b1;
        d_rdata_o  = ram_rdata_i;
        d_err_o    = ram_unalign_i;
      end
      RESP_D_ST: begin
        d_err_o = ram_unalign_i;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port synchronous RAM between the instruction-fetch requester (IF stage) and the data requester (MEM stage). Grants at most one access per cycle and drives the RAM control bus. Routes the next-cycle read data and access errors back to the requester that owns that access. Produces a fetch stall so the PC holds while fetch is denied.

Parameters:
ADDR_WIDTH, 16, RAM byte-address width
DATA_WIDTH, 64, data-port width
INST_WIDTH, 32, fetch-word width
STARVE_MAX, 3, consecutive fetch denials after which fetch wins one arbitration

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-low (0 = reset)
if_req_i  in  1  fetch request
if_addr_i  in  ADDR_WIDTH  fetch address
if_kill_i  in  1  flush: discard any fetch response due this cycle
if_gnt_o  out  1  fetch granted this cycle
if_stall_o  out  1  if_req_i & ~if_gnt_o
if_rvalid_o  out  1  fetch data valid (one cycle after grant)
if_rdata_o  out  INST_WIDTH  fetch data
if_err_o  out  1  illegal fetch access, qualified by if_rvalid_o
d_req_i  in  1  data request
d_we_i  in  1  1 = store, 0 = load
d_addr_i  in  ADDR_WIDTH  data address
d_wdata_i  in  DATA_WIDTH  store data
d_wid_i  in  3  access width/sign (Detail encoding)
d_gnt_o  out  1  data granted this cycle
d_rvalid_o  out  1  load data valid (one cycle after load grant)
d_rdata_o  out  DATA_WIDTH  load data
d_err_o  out  1  unaligned data access, pulses with d_rvalid_o for loads or one cycle after store grant
ram_en_o  out  1  RAM access enable
ram_we_o  out  1  RAM write enable
ram_addr_o  out  ADDR_WIDTH  RAM address
ram_wdata_o  out  DATA_WIDTH  RAM write data
ram_wid_o  out  3  RAM width
ram_rdata_i  in  DATA_WIDTH  RAM read data, valid the cycle after ram_en_o
ram_illegal_i  in  1  illegal-access flag, aligned with ram_rdata_i
ram_unalign_i  in  1  unaligned flag, aligned with ram_rdata_i

Behaviour:
- Grant logic is combinational, same cycle. The RAM bus mirrors the winning requester. If nothing is granted: ram_en_o=0, ram_we_o=0, and address/data are don't-care but driven to 0.
- Default priority: data wins. Fetch wins if starve_cnt == STARVE_MAX and if_req_i=1.
- starve_cnt (2+ bits): increments, saturating at STARVE_MAX, on cycles where if_req_i=1 and fetch is not granted. Clears on any fetch grant or when if_req_i=0.
- Response tracker is a registered FSM with states IDLE, RESP_IF, RESP_D_LD, RESP_D_ST. It is loaded every cycle from that cycle's grant:
  - fetch grant → RESP_IF
  - load grant → RESP_D_LD
  - store grant → RESP_D_ST
  - no grant → IDLE
- In RESP_IF:
  - if_rvalid_o = ~if_kill_i
  - if_rdata_o = ram_rdata_i[INST_WIDTH-1:0]
  - if_err_o = ram_illegal_i & ~if_kill_i
- In RESP_D_LD:
  - d_rvalid_o = 1
  - d_rdata_o = ram_rdata_i
  - d_err_o = ram_unalign_i
- In RESP_D_ST: d_err_o = ram_unalign_i, d_rvalid_o = 0.
- All other rvalid/err outputs are 0. rdata outputs are 0 when not valid.
- Back-to-back grants are allowed every cycle. A new grant's response overlaps the previous grant's return with no bubble.
- if_kill_i only suppresses a response that is due. A fetch request in the same cycle is still arbitrated normally.
- Reset (rst_i=0 at a clock edge):
  - FSM goes to IDLE; starve_cnt goes to 0.
  - Every registered output is 0. Combinational outputs follow from IDLE with no grant: all gnt/rvalid/err = 0, ram_en_o = 0.
  - Reset during an access drops its response; no rvalid appears in the cycle after reset.
  - While rst_i=0, no grants are issued and the RAM bus is idle.
- if_stall_o = if_req_i & ~if_gnt_o. It is held low during reset.

Test Plan:
- Fetch-only: if_req_i=1, if_addr_i=0x0100 for 4 cycles → if_gnt_o=1 each cycle; ram_addr_o=0x0100; if_rvalid_o=1 from cycle 2 with if_rdata_o equal to the RAM word.
- Contention: both requests held for 5 cycles, d_we_i=0 → grants D,D,D,IF,D; if_stall_o=1,1,1,0,1; starve_cnt=3 on the 4th cycle.
- Store then load to 0x0208, d_wid_i=dword: store with wdata 0xDEADBEEF_CAFEF00D, then load → ram_we_o=1 then 0; d_rvalid_o only after the load, d_rdata_o=0xDEADBEEF_CAFEF00D.
- Kill: fetch granted in cycle N, if_kill_i=1 in cycle N+1 → if_rvalid_o=0 and if_err_o=0 even with ram_illegal_i=1.
- Errors: load at 0x0203 with dword width and ram_unalign_i=1 returned → d_rvalid_o=1, d_err_o=1, if_err_o=0.
- Reset mid-access: grant a load, assert rst_i=0 next edge → d_rvalid_o=0, ram_en_o=0, starve_cnt=0; the first post-reset fetch is granted immediately.
